// File: rtl/timing_generator_prog_if.sv
// Bus bundle for timing_generator_prog: enable and config request toward the
// generator, video timing and config status back from it.
interface timing_generator_prog_if #(
  parameter int unsigned CW = 11,
  parameter int unsigned FW = 8
);
  logic            i_en;
  logic            i_cfg_req;
  logic [4*CW-1:0] i_cfg_h;
  logic [4*CW-1:0] i_cfg_v;
  logic [1:0]      i_cfg_pol;
  logic            o_cfg_pend;
  logic            o_cfg_done;
  logic            o_cfg_err;
  logic            o_de;
  logic            o_hs;
  logic            o_vs;
  logic [CW-1:0]   o_x;
  logic [CW-1:0]   o_y;
  logic            o_sol;
  logic            o_sof;
  logic [FW-1:0]   o_frame;

  modport master (
    output i_en, i_cfg_req, i_cfg_h, i_cfg_v, i_cfg_pol,
    input  o_cfg_pend, o_cfg_done, o_cfg_err, o_de, o_hs, o_vs,
           o_x, o_y, o_sol, o_sof, o_frame
  );

  modport slave (
    input  i_en, i_cfg_req, i_cfg_h, i_cfg_v, i_cfg_pol,
    output o_cfg_pend, o_cfg_done, o_cfg_err, o_de, o_hs, o_vs,
           o_x, o_y, o_sol, o_sof, o_frame
  );
endinterface

// File: rtl/timing_generator_prog.sv
// Run-time programmable video timing generator: DE/HS/VS, coordinates, frame strobes,
// with validated config requests that take effect only at a frame boundary.
module timing_generator_prog #(
  parameter int unsigned CW     = 11,
  parameter int unsigned FW     = 8,
  parameter int unsigned D_HAC  = 640,
  parameter int unsigned D_HFP  = 16,
  parameter int unsigned D_HSP  = 96,
  parameter int unsigned D_HBP  = 48,
  parameter int unsigned D_VAC  = 480,
  parameter int unsigned D_VFP  = 10,
  parameter int unsigned D_VSP  = 2,
  parameter int unsigned D_VBP  = 33,
  parameter int unsigned D_HPOL = 0,
  parameter int unsigned D_VPOL = 0
) (
  input logic                    i_clk,
  input logic                    i_rst,
  timing_generator_prog_if.slave bus
);

  localparam int unsigned SW = CW + 2;
  localparam logic [SW-1:0] MAX_TOT = SW'((2 ** CW) - 1);

  typedef struct packed {
    logic [CW-1:0] hac, hfp, hsp, hbp;
    logic [CW-1:0] vac, vfp, vsp, vbp;
    logic          vpol, hpol;
  } cfg_t;

  localparam cfg_t DEF_CFG = '{
    hac: CW'(D_HAC), hfp: CW'(D_HFP), hsp: CW'(D_HSP), hbp: CW'(D_HBP),
    vac: CW'(D_VAC), vfp: CW'(D_VFP), vsp: CW'(D_VSP), vbp: CW'(D_VBP),
    vpol: 1'(D_VPOL), hpol: 1'(D_HPOL)
  };

  typedef enum logic {ST_IDLE = 1'b0, ST_PEND = 1'b1} pend_st_t;

  function automatic logic [SW-1:0] ext(input logic [CW-1:0] v);
    return SW'(v);
  endfunction

  cfg_t          req_cfg, act_q, pend_q;
  logic [SW-1:0] req_htot, req_vtot;
  logic          req_ok, req_valid;
  pend_st_t      st_q, st_d;

  logic [CW-1:0] nx_q, ny_q, nx_d, ny_d;
  logic [SW-1:0] act_htot, act_vtot, hs_start, hs_end, vs_start, vs_end;
  logic          h_last, v_last, wrap, apply;
  logic          de_d, hs_d, vs_d, sol_d, sof_d;

  logic [CW-1:0] x_q, y_q;
  logic          de_q, hs_q, vs_q, sol_q, sof_q;
  logic [FW-1:0] frame_q;
  logic          started_q, done_q, err_q;

  // Request decode and validation; totals are summed wide so overflow is visible.
  always_comb begin
    req_cfg = '{
      hac: bus.i_cfg_h[4*CW-1 -: CW], hfp: bus.i_cfg_h[3*CW-1 -: CW],
      hsp: bus.i_cfg_h[2*CW-1 -: CW], hbp: bus.i_cfg_h[CW-1 -: CW],
      vac: bus.i_cfg_v[4*CW-1 -: CW], vfp: bus.i_cfg_v[3*CW-1 -: CW],
      vsp: bus.i_cfg_v[2*CW-1 -: CW], vbp: bus.i_cfg_v[CW-1 -: CW],
      vpol: bus.i_cfg_pol[1], hpol: bus.i_cfg_pol[0]
    };
    req_htot = ext(req_cfg.hac) + ext(req_cfg.hfp) + ext(req_cfg.hsp) + ext(req_cfg.hbp);
    req_vtot = ext(req_cfg.vac) + ext(req_cfg.vfp) + ext(req_cfg.vsp) + ext(req_cfg.vbp);
    req_ok   = (req_cfg.hac != '0) && (req_cfg.hfp != '0) && (req_cfg.hsp != '0) &&
               (req_cfg.hbp != '0) && (req_cfg.vac != '0) && (req_cfg.vfp != '0) &&
               (req_cfg.vsp != '0) && (req_cfg.vbp != '0) &&
               (req_htot <= MAX_TOT) && (req_vtot <= MAX_TOT);
    req_valid = bus.i_cfg_req && req_ok;
  end

  // Next position and the outputs that describe it.
  always_comb begin
    act_htot = ext(act_q.hac) + ext(act_q.hfp) + ext(act_q.hsp) + ext(act_q.hbp);
    act_vtot = ext(act_q.vac) + ext(act_q.vfp) + ext(act_q.vsp) + ext(act_q.vbp);
    hs_start = ext(act_q.hac) + ext(act_q.hfp);
    hs_end   = hs_start + ext(act_q.hsp);
    vs_start = ext(act_q.vac) + ext(act_q.vfp);
    vs_end   = vs_start + ext(act_q.vsp);

    h_last = (ext(nx_q) == act_htot - SW'(1));
    v_last = (ext(ny_q) == act_vtot - SW'(1));
    wrap   = h_last && v_last;
    apply  = bus.i_en && wrap && (st_q == ST_PEND);

    nx_d = nx_q + CW'(1);
    ny_d = ny_q;
    if (h_last) begin
      nx_d = '0;
      ny_d = v_last ? '0 : ny_q + CW'(1);
    end

    de_d  = (nx_q < act_q.hac) && (ny_q < act_q.vac);
    hs_d  = ((ext(nx_q) >= hs_start) && (ext(nx_q) < hs_end)) ~^ act_q.hpol;
    vs_d  = ((ext(ny_q) >= vs_start) && (ext(ny_q) < vs_end)) ~^ act_q.vpol;
    sol_d = (nx_q == '0);
    sof_d = sol_d && (ny_q == '0);
  end

  // Pending-config state: a valid request always (re)arms, apply clears.
  always_comb begin
    st_d = st_q;
    case (st_q)
      ST_IDLE: if (req_valid) st_d = ST_PEND;
      ST_PEND: if (req_valid) st_d = ST_PEND;
               else if (apply) st_d = ST_IDLE;
      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) st_q <= ST_IDLE;
    else       st_q <= st_d;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      act_q     <= DEF_CFG;
      pend_q    <= DEF_CFG;
      nx_q      <= '0;
      ny_q      <= '0;
      x_q       <= '0;
      y_q       <= '0;
      de_q      <= 1'b0;
      hs_q      <= ~1'(D_HPOL);
      vs_q      <= ~1'(D_VPOL);
      sol_q     <= 1'b0;
      sof_q     <= 1'b0;
      frame_q   <= '0;
      started_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      err_q  <= bus.i_cfg_req && !req_ok;
      done_q <= apply;
      if (req_valid) pend_q <= req_cfg;
      if (bus.i_en) begin
        x_q       <= nx_q;
        y_q       <= ny_q;
        de_q      <= de_d;
        hs_q      <= hs_d;
        vs_q      <= vs_d;
        sol_q     <= sol_d;
        sof_q     <= sof_d;
        nx_q      <= nx_d;
        ny_q      <= ny_d;
        started_q <= 1'b1;
        // The very first frame after reset is frame 0, not 1.
        if (sof_d && started_q) frame_q <= frame_q + FW'(1);
        if (apply) act_q <= pend_q;
      end
    end
  end

  assign bus.o_x        = x_q;
  assign bus.o_y        = y_q;
  assign bus.o_de       = de_q;
  assign bus.o_hs       = hs_q;
  assign bus.o_vs       = vs_q;
  assign bus.o_sol      = sol_q;
  assign bus.o_sof      = sof_q;
  assign bus.o_frame    = frame_q;
  assign bus.o_cfg_pend = (st_q == ST_PEND);
  assign bus.o_cfg_done = done_q;
  assign bus.o_cfg_err  = err_q;

endmodule

// File: tb/tb_timing_generator_prog.sv
// Bench for timing_generator_prog using small default timings so whole frames stay short;
// an output-side reference model plus hand-computed per-frame statistics and config vectors.
module tb_timing_generator_prog;

  localparam int unsigned CW  = 11;
  localparam int unsigned FW  = 8;
  localparam int unsigned FLD = 4 * CW;

  typedef struct {
    int hac, hfp, hsp, hbp, vac, vfp, vsp, vbp;
    bit hpol, vpol;
  } mcfg_t;

  typedef struct {
    string          name;
    logic [FLD-1:0] h;
    logic [FLD-1:0] v;
    logic [1:0]     pol;
    bit             exp_err;
  } req_vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  timing_generator_prog_if #(.CW(CW), .FW(FW)) bus ();

  timing_generator_prog #(
    .CW(CW), .FW(FW),
    .D_HAC(8), .D_HFP(2), .D_HSP(3), .D_HBP(2),
    .D_VAC(4), .D_VFP(1), .D_VSP(2), .D_VBP(1),
    .D_HPOL(0), .D_VPOL(0)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus(bus)
  );

  int       n_checks = 0;
  int       n_fail = 0;
  int       n_done_seen = 0;
  mcfg_t    def_cfg, mc, mp, staged;
  bit       mfirst, mpend, mswap, done_e, err_e;
  int       ex, ey, ef;
  req_vec_t tbl[6];

  function automatic logic [FLD-1:0] pack4(input int a, input int b, input int c, input int d);
    return {CW'(a), CW'(b), CW'(c), CW'(d)};
  endfunction

  function automatic mcfg_t unpack(input logic [FLD-1:0] h, input logic [FLD-1:0] v,
                                   input logic [1:0] pol);
    mcfg_t c;
    c.hac = int'(h[4*CW-1 -: CW]); c.hfp = int'(h[3*CW-1 -: CW]);
    c.hsp = int'(h[2*CW-1 -: CW]); c.hbp = int'(h[CW-1 -: CW]);
    c.vac = int'(v[4*CW-1 -: CW]); c.vfp = int'(v[3*CW-1 -: CW]);
    c.vsp = int'(v[2*CW-1 -: CW]); c.vbp = int'(v[CW-1 -: CW]);
    c.vpol = pol[1];
    c.hpol = pol[0];
    return c;
  endfunction

  function automatic int htot(input mcfg_t c);
    return c.hac + c.hfp + c.hsp + c.hbp;
  endfunction

  function automatic int vtot(input mcfg_t c);
    return c.vac + c.vfp + c.vsp + c.vbp;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mfirst = 1'b1; mc = def_cfg; mpend = 1'b0; mswap = 1'b0;
    ex = 0; ey = 0; ef = 0; done_e = 1'b0; err_e = 1'b0;
  endtask

  // Compare every output against what the model says the screen shows now.
  task automatic cmp_all();
    int   xx, yy, s;
    logic e_de, e_hs, e_vs, e_sol, e_sof;
    if (mfirst) begin
      xx = 0; yy = 0; e_de = 1'b0; e_sol = 1'b0; e_sof = 1'b0; e_hs = 1'b1; e_vs = 1'b1;
    end else begin
      xx = ex; yy = ey;
      e_de  = (ex < mc.hac) && (ey < mc.vac);
      s     = mc.hac + mc.hfp;
      e_hs  = ((ex >= s) && (ex < s + mc.hsp)) ? mc.hpol : !mc.hpol;
      s     = mc.vac + mc.vfp;
      e_vs  = ((ey >= s) && (ey < s + mc.vsp)) ? mc.vpol : !mc.vpol;
      e_sol = (ex == 0);
      e_sof = (ex == 0) && (ey == 0);
    end
    check("x", 64'(bus.o_x), 64'(xx));
    check("y", 64'(bus.o_y), 64'(yy));
    check("de", 64'(bus.o_de), 64'(e_de));
    check("hs", 64'(bus.o_hs), 64'(e_hs));
    check("vs", 64'(bus.o_vs), 64'(e_vs));
    check("sol", 64'(bus.o_sol), 64'(e_sol));
    check("sof", 64'(bus.o_sof), 64'(e_sof));
    check("frame", 64'(bus.o_frame), 64'(ef % 256));
    check("cfg_pend", 64'(bus.o_cfg_pend), 64'(mpend));
    check("cfg_done", 64'(bus.o_cfg_done), 64'(done_e));
    check("cfg_err", 64'(bus.o_cfg_err), 64'(err_e));
  endtask

  task automatic do_cycle(input bit en, input bit req, input logic [FLD-1:0] h,
                          input logic [FLD-1:0] v, input logic [1:0] pol, input bit exp_err);
    bus.i_en = en; bus.i_cfg_req = req; bus.i_cfg_h = h; bus.i_cfg_v = v; bus.i_cfg_pol = pol;
    @(posedge clk);
    #1;
    done_e = 1'b0;
    err_e  = req && exp_err;
    if (en) begin
      if (mfirst) begin
        mfirst = 1'b0; ex = 0; ey = 0;
      end else if (ex == htot(mc) - 1 && ey == vtot(mc) - 1) begin
        ex = 0; ey = 0; ef++;
        if (mswap) begin mc = staged; mswap = 1'b0; end
      end else if (ex == htot(mc) - 1) begin
        ex = 0; ey++;
      end else begin
        ex++;
      end
      // Showing the last pixel of a frame is when a waiting config is taken.
      if (ex == htot(mc) - 1 && ey == vtot(mc) - 1 && mpend) begin
        done_e = 1'b1; staged = mp; mswap = 1'b1; mpend = 1'b0;
      end
    end
    if (req && !exp_err) begin
      mp = unpack(h, v, pol); mpend = 1'b1;
    end
    cmp_all();
    if (bus.o_cfg_done === 1'b1) n_done_seen++;
    bus.i_cfg_req = 1'b0;
  endtask

  task automatic idle(input bit en);
    do_cycle(en, 1'b0, '0, '0, 2'b00, 1'b0);
  endtask

  // Starting on a sof sample, run one frame and check its length and signal counts.
  task automatic measure_frame(input string tag, input bit hpol, input bit vpol,
                               input int e_len, input int e_de, input int e_hs, input int e_vs);
    int len, nde, nhs, nvs;
    len = 0; nde = 0; nhs = 0; nvs = 0;
    check({tag, "_start_sof"}, 64'(bus.o_sof), 64'(1));
    do begin
      len++;
      nde += int'(bus.o_de);
      nhs += int'(bus.o_hs == hpol);
      nvs += int'(bus.o_vs == vpol);
      idle(1'b1);
    end while (bus.o_sof !== 1'b1 && len < 5000);
    check({tag, "_len"}, 64'(len), 64'(e_len));
    check({tag, "_de_cnt"}, 64'(nde), 64'(e_de));
    check({tag, "_hs_cnt"}, 64'(nhs), 64'(e_hs));
    check({tag, "_vs_cnt"}, 64'(nvs), 64'(e_vs));
  endtask

  task automatic run_to_sof(input string tag);
    int n;
    n = 0;
    do begin
      idle(1'b1);
      n++;
    end while (bus.o_sof !== 1'b1 && n < 5000);
    check({tag, "_reach_sof"}, 64'(bus.o_sof), 64'(1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    def_cfg = '{hac: 8, hfp: 2, hsp: 3, hbp: 2, vac: 4, vfp: 1, vsp: 2, vbp: 1,
                hpol: 1'b0, vpol: 1'b0};
    tbl[0] = '{"hsp_zero",  pack4(8, 2, 0, 2),       pack4(4, 1, 2, 1),       2'b00, 1'b1};
    tbl[1] = '{"hac_2000",  pack4(2000, 16, 96, 48), pack4(4, 1, 2, 1),       2'b00, 1'b1};
    tbl[2] = '{"vbp_zero",  pack4(8, 2, 3, 2),       pack4(4, 1, 2, 0),       2'b00, 1'b1};
    tbl[3] = '{"htot_2047", pack4(2000, 16, 16, 15), pack4(4, 1, 2, 1),       2'b00, 1'b0};
    tbl[4] = '{"vtot_2048", pack4(8, 2, 3, 2),       pack4(2000, 16, 16, 16), 2'b00, 1'b1};
    tbl[5] = '{"last_wins", pack4(6, 1, 2, 1),       pack4(3, 1, 1, 1),       2'b11, 1'b0};

    bus.i_en = 1'b0; bus.i_cfg_req = 1'b0; bus.i_cfg_h = '0; bus.i_cfg_v = '0; bus.i_cfg_pol = '0;
    model_reset();

    // Reset values, held even with enable high.
    #12;
    cmp_all();
    bus.i_en = 1'b1;
    @(posedge clk);
    #1;
    cmp_all();
    rst = 1'b0;
    idle(1'b1);
    check("a_first_x", 64'(bus.o_x), 64'(0));
    check("a_first_de", 64'(bus.o_de), 64'(1));
    check("a_first_sof", 64'(bus.o_sof), 64'(1));
    check("a_first_sol", 64'(bus.o_sol), 64'(1));
    check("a_first_frame", 64'(bus.o_frame), 64'(0));

    // Two default frames: 15x8 total, hs low x=10..12, vs low y=5..6.
    measure_frame("b_f0", 1'b0, 1'b0, 120, 32, 24, 30);
    check("b_frame1", 64'(bus.o_frame), 64'(1));
    measure_frame("b_f1", 1'b0, 1'b0, 120, 32, 24, 30);
    check("b_frame2", 64'(bus.o_frame), 64'(2));

    // Config validation vectors, issued mid-frame.
    for (int i = 0; i < 20; i++) idle(1'b1);
    for (int i = 0; i < 6; i++) begin
      do_cycle(1'b1, 1'b1, tbl[i].h, tbl[i].v, tbl[i].pol, tbl[i].exp_err);
      check({"tbl_err_", tbl[i].name}, 64'(bus.o_cfg_err), 64'(tbl[i].exp_err));
      if (i == 0) check("tbl_pend_after_reject", 64'(bus.o_cfg_pend), 64'(0));
    end
    idle(1'b1);
    check("c_pend", 64'(bus.o_cfg_pend), 64'(1));

    // Old timing runs out; the last valid request (10x6, pol 11) takes over.
    n_done_seen = 0;
    run_to_sof("d");
    check("d_done_count", 64'(n_done_seen), 64'(1));
    check("d_pend_clear", 64'(bus.o_cfg_pend), 64'(0));
    measure_frame("d_new", 1'b1, 1'b1, 60, 18, 12, 10);

    // Request on the wrap edge waits a full frame.
    n = 0;
    while (!(ex == 8 && ey == 5) && n < 5000) begin idle(1'b1); n++; end
    check("e_align_x", 64'(bus.o_x), 64'(8));
    do_cycle(1'b1, 1'b1, pack4(8, 2, 3, 2), pack4(4, 1, 2, 1), 2'b00, 1'b0);
    check("e_wrap_x", 64'(bus.o_x), 64'(9));
    check("e_wrap_pend", 64'(bus.o_cfg_pend), 64'(1));
    check("e_wrap_done", 64'(bus.o_cfg_done), 64'(0));
    idle(1'b1);
    measure_frame("e_hold", 1'b1, 1'b1, 60, 18, 12, 10);
    measure_frame("e_new", 1'b0, 1'b0, 120, 32, 24, 30);

    // Random stalls; model only advances on enabled edges.
    for (int i = 0; i < 300; i++) idle(1'(($urandom_range(0, 1))));
    run_to_sof("f");

    // Mid-frame async reset discards a pending config.
    for (int i = 0; i < 37; i++) idle(1'b1);
    do_cycle(1'b1, 1'b1, pack4(6, 1, 2, 1), pack4(3, 1, 1, 1), 2'b11, 1'b0);
    check("g_pend_before", 64'(bus.o_cfg_pend), 64'(1));
    #3 rst = 1'b1;
    #1;
    model_reset();
    cmp_all();
    @(posedge clk);
    #1;
    cmp_all();
    rst = 1'b0;
    idle(1'b0);
    idle(1'b1);
    check("g_first_sof", 64'(bus.o_sof), 64'(1));
    check("g_first_frame", 64'(bus.o_frame), 64'(0));
    measure_frame("g_def", 1'b0, 1'b0, 120, 32, 24, 30);
    check("g_pend_after", 64'(bus.o_cfg_pend), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
